ex_mem_skid_stage: RTL and testbench

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

---
 rtl/ex_mem_skid_stage.sv | 115 +++++++++++
 tb/tb_ex_mem_skid_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM pipeline register, skid buffer enabled by EX_MEM_SKID_EN
// Without EX_MEM_SKID_EN the stage is one register with a combinational in_ready.
module ex_mem_skid_stage #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_waddr,
    input  logic          in_wen,
    input  logic [DW-1:0] in_alures,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_waddr,
    output logic          out_wen,
    output logic [DW-1:0] out_alures,
    output logic [1:0]    occ
);
    logic          main_valid_q, main_valid_d;
    logic [AW-1:0] main_waddr_q, main_waddr_d;
    logic          main_wen_q, main_wen_d;
    logic [DW-1:0] main_alures_q, main_alures_d;
    logic          acc, drain;

    // a beat offered during flush is discarded, so it never counts as accepted
    assign acc        = in_valid && in_ready && !flush;
    assign drain      = main_valid_q && out_ready;
    assign out_valid  = main_valid_q;
    assign out_waddr  = main_waddr_q;
    assign out_wen    = main_wen_q && main_valid_q;
    assign out_alures = main_alures_q;

`ifdef EX_MEM_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [AW-1:0] skid_waddr_q, skid_waddr_d;
    logic          skid_wen_q, skid_wen_d;
    logic [DW-1:0] skid_alures_q, skid_alures_d;

    assign in_ready = !skid_valid_q;
    assign occ      = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d  = main_valid_q;
        main_waddr_d  = main_waddr_q;
        main_wen_d    = main_wen_q;
        main_alures_d = main_alures_q;
        skid_valid_d  = skid_valid_q;
        skid_waddr_d  = skid_waddr_q;
        skid_wen_d    = skid_wen_q;
        skid_alures_d = skid_alures_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            main_waddr_d  = skid_waddr_q;
            main_wen_d    = skid_wen_q;
            main_alures_d = skid_alures_q;
            skid_valid_d  = 1'b0;
        end else if (acc && (!main_valid_q || drain)) begin
            main_valid_d  = 1'b1;
            main_waddr_d  = in_waddr;
            main_wen_d    = in_wen;
            main_alures_d = in_alures;
        end else if (acc) begin
            skid_valid_d  = 1'b1;
            skid_waddr_d  = in_waddr;
            skid_wen_d    = in_wen;
            skid_alures_d = in_alures;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q  <= 1'b0;
            skid_waddr_q  <= '0;
            skid_wen_q    <= 1'b0;
            skid_alures_q <= '0;
        end else begin
            skid_valid_q  <= skid_valid_d;
            skid_waddr_q  <= skid_waddr_d;
            skid_wen_q    <= skid_wen_d;
            skid_alures_q <= skid_alures_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;
    assign occ      = {1'b0, main_valid_q};

    always_comb begin
        main_valid_d  = flush ? 1'b0 : acc ? 1'b1 : drain ? 1'b0 : main_valid_q;
        main_waddr_d  = acc ? in_waddr : main_waddr_q;
        main_wen_d    = acc ? in_wen : main_wen_q;
        main_alures_d = acc ? in_alures : main_alures_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q  <= 1'b0;
            main_waddr_q  <= '0;
            main_wen_q    <= 1'b0;
            main_alures_q <= '0;
        end else begin
            main_valid_q  <= main_valid_d;
            main_waddr_q  <= main_waddr_d;
            main_wen_q    <= main_wen_d;
            main_alures_q <= main_alures_d;
        end
    end
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: directed checks plus an ordered-stream run for ex_mem_skid_stage
// Expectations follow EX_MEM_SKID_EN the same way the design does.
module tb_ex_mem_skid_stage;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef EX_MEM_SKID_EN
    localparam int MAXOCC = 2;
`else
    localparam int MAXOCC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, in_wen;
    logic          out_valid, out_ready, out_wen;
    logic [AW-1:0] in_waddr, out_waddr;
    logic [DW-1:0] in_alures, out_alures;
    logic [1:0]    occ;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_waddr(in_waddr), .in_wen(in_wen), .in_alures(in_alures),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_waddr(out_waddr), .out_wen(out_wen), .out_alures(out_alures),
        .occ(occ)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        in_valid  = 1'b1;
        in_waddr  = a;
        in_wen    = w;
        in_alures = d;
    endtask

    task automatic empty_out();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    logic [37:0] sb[$];
    logic [37:0] beat;
    int sent, rcvd, cyc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_waddr = '0; in_wen = 1'b0; in_alures = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_waddr", out_waddr, 0);
        chk("rst_out_wen", out_wen, 0);
        chk("rst_out_alures", out_alures, 0);
        chk("rst_occ", occ, 0);
        chk("rst_in_ready", in_ready, 1);

        // single beat, 1-cycle latency
        out_ready = 1'b1;
        offer(5'h03, 1'b1, 32'h0000_00AA);
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_waddr", out_waddr, 5'h03);
        chk("lat_out_wen", out_wen, 1);
        chk("lat_out_alures", out_alures, 32'hAA);
        chk("lat_occ", occ, 1);
        tick();
        chk("lat_drained_occ", occ, 0);
        chk("lat_wen_forced", out_wen, 0);

        // backpressure
        out_ready = 1'b0;
        offer(5'h01, 1'b1, 32'h11);
        tick();
        offer(5'h02, 1'b1, 32'h22);
        #1;
`ifdef EX_MEM_SKID_EN
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_occ2", occ, 2);
        chk("bp_in_ready0", in_ready, 0);
        chk("bp_head11", out_alures, 32'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_head22", out_alures, 32'h22);
        chk("bp_waddr2", out_waddr, 5'h02);
        chk("bp_occ1", occ, 1);
        chk("bp_in_ready1", in_ready, 1);
        tick();
        chk("bp_occ0", occ, 0);
`else
        chk("bp_in_ready0", in_ready, 0);
        tick();
        chk("bp_hold_occ1", occ, 1);
        chk("bp_hold_head11", out_alures, 32'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_comb_in_ready1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_pass_occ1", occ, 1);
        chk("bp_head22", out_alures, 32'h22);
        tick();
        chk("bp_occ0", occ, 0);
`endif
        empty_out();

        // flush discards held beats and the beat offered alongside it
        out_ready = 1'b0;
        offer(5'h04, 1'b1, 32'h44);
        tick();
        offer(5'h05, 1'b1, 32'h55);
        tick();
        flush = 1'b1;
        offer(5'h06, 1'b1, 32'h33);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_occ", occ, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_wen", out_wen, 0);
        chk("fl_payload_hold", out_alures, 32'h44);
        out_ready = 1'b1;
        tick();
        chk("fl_no33_valid", out_valid, 0);
        chk("fl_no33_data", out_alures, 32'h44);
        empty_out();

        // accept and drain together at occ=1
        out_ready = 1'b0;
        offer(5'h07, 1'b0, 32'h66);
        tick();
        out_ready = 1'b1;
        offer(5'h08, 1'b1, 32'h77);
        tick();
        in_valid = 1'b0;
        #1;
        chk("ad_occ1", occ, 1);
        chk("ad_head77", out_alures, 32'h77);
        chk("ad_waddr8", out_waddr, 5'h08);
        empty_out();

        // ordered stream under toggling backpressure
        sent = 0; rcvd = 0; cyc = 0;
        beat = 38'({$urandom(), $urandom()});
        while ((sent < 100 || rcvd < sent) && cyc < 1000) begin
            in_valid = (sent < 100);
            {in_waddr, in_wen, in_alures} = beat;
            out_ready = (cyc % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("stream_extra", 1, 0);
                else chk("stream_beat", {out_waddr, out_wen, out_alures}, sb.pop_front());
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(beat);
                sent++;
                beat = 38'({$urandom(), $urandom()});
            end
            chk("stream_occ_max", occ <= 2'(MAXOCC), 1);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", rcvd, 100);
        chk("stream_bound", cyc < 1000, 1);

        // reset beats flush and a pending offer with the stage full
        out_ready = 1'b0;
        offer(5'h09, 1'b1, 32'h99);
        tick();
        offer(5'h0A, 1'b1, 32'hBB);
        tick();
        chk("rf_full_occ", occ, 2'(MAXOCC));
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rf_out_valid", out_valid, 0);
        chk("rf_out_waddr", out_waddr, 0);
        chk("rf_out_wen", out_wen, 0);
        chk("rf_out_alures", out_alures, 0);
        chk("rf_occ", occ, 0);
        chk("rf_in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
